// File: rtl/simon_seq_engine.sv
// Simon game core: LFSR-driven key sequence, LED playback and player key checking.
// Optional per-key-press timeout is enabled by defining SIMON_TIMEOUT_EN.
module simon_seq_engine #(
    parameter int NUM_KEYS       = 4,
    parameter int MAX_LEN        = 32,
    parameter int SHOW_CYCLES    = 12_500_000,
    parameter int GAP_CYCLES     = 2_500_000,
    parameter int TIMEOUT_CYCLES = 125_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                key_valid,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] led_out,
    output logic [7:0]          level,
    output logic                busy,
    output logic                win,
    output logic                lose
);
    localparam int K    = (NUM_KEYS <= 2) ? 1 : $clog2(NUM_KEYS);
    localparam int AW   = (MAX_LEN <= 2) ? 1 : $clog2(MAX_LEN);
    localparam int MAXC = (SHOW_CYCLES > GAP_CYCLES)
                        ? ((SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES)
                        : ((GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES);
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [NUM_KEYS-1:0] ONE = {{(NUM_KEYS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE, EXTEND, SHOW_ON, SHOW_GAP, WAIT_IN, WIN, LOSE
    } state_t;

    state_t              state;
    logic [15:0]         lfsr;
    logic [7:0]          len;
    logic [7:0]          ptr;
    logic [CW-1:0]       cnt;
    logic [NUM_KEYS-1:0] led_r;
    logic                pregap;
    logic [K-1:0]        seq [MAX_LEN];

    logic [K:0]          raw_idx;
    logic [K-1:0]        new_idx;
    logic [7:0]          ptr_inc;
    logic [NUM_KEYS-1:0] exp_key;

    // Fold out-of-range LFSR values back into 0..NUM_KEYS-1.
    always_comb begin
        raw_idx = {1'b0, lfsr[K-1:0]};
        new_idx = raw_idx[K-1:0];
        if (raw_idx >= (K+1)'(NUM_KEYS))
            new_idx = K'(raw_idx - (K+1)'(NUM_KEYS));
    end

    assign ptr_inc = ptr + 8'd1;
    assign exp_key = ONE << seq[ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (state == EXTEND)
            seq[len[AW-1:0]] <= new_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            lfsr   <= 16'hACE1;
            len    <= 8'd0;
            ptr    <= 8'd0;
            cnt    <= '0;
            led_r  <= '0;
            pregap <= 1'b0;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            cnt  <= '0;
            case (state)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        len    <= 8'd0;
                        pregap <= 1'b0;
                        state  <= EXTEND;
                    end
                end
                EXTEND: begin
                    len   <= len + 8'd1;
                    ptr   <= 8'd0;
                    // seq[0] is being written this cycle on the first round
                    led_r <= ONE << ((len == 8'd0) ? new_idx : seq[0]);
                    state <= SHOW_ON;
                end
                SHOW_ON: begin
                    if (cnt == CW'(SHOW_CYCLES - 1)) begin
                        led_r <= '0;
                        state <= SHOW_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW_GAP: begin
                    if (cnt != CW'(GAP_CYCLES - 1)) begin
                        cnt <= cnt + 1'b1;
                    end else if (pregap) begin
                        pregap <= 1'b0;
                        state  <= EXTEND;
                    end else if (ptr == len - 8'd1) begin
                        ptr   <= 8'd0;
                        state <= WAIT_IN;
                    end else begin
                        ptr   <= ptr_inc;
                        led_r <= ONE << seq[ptr_inc[AW-1:0]];
                        state <= SHOW_ON;
                    end
                end
                WAIT_IN: begin
                    if (key_valid) begin
                        if (key_in != exp_key) begin
                            state <= LOSE;
                        end else if (ptr != len - 8'd1) begin
                            ptr <= ptr_inc;
                        end else if (len == 8'(MAX_LEN)) begin
                            state <= WIN;
                        end else begin
                            ptr    <= 8'd0;
                            pregap <= 1'b1;
                            state  <= SHOW_GAP;
                        end
                    end
`ifdef SIMON_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state <= LOSE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Key presses are echoed on the LEDs in the cycle they arrive.
    assign led_out = (state == WAIT_IN && key_valid) ? key_in : led_r;
    assign level   = len;
    assign busy    = !(state == IDLE || state == WIN || state == LOSE);
    assign win     = (state == WIN);
    assign lose    = (state == LOSE);
endmodule

// File: tb/tb_simon_seq_engine.sv
// Scoreboard bench for simon_seq_engine: predicted LED sequence queued at each
// extension and popped during playback; a second instance covers NUM_KEYS=3.
module tb_simon_seq_engine;
    localparam int NK = 4;
    localparam int SC = 3;
    localparam int GC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_in = 4'b0;
    logic [3:0] led_out;
    logic [7:0] level;
    logic       busy, win, lose;

    logic       start3 = 1'b0;
    logic       kv3 = 1'b0;
    logic [2:0] key3 = 3'b0;
    logic [2:0] led3;
    logic [7:0] level3;
    logic       busy3, win3, lose3;

    int n_tests = 0;
    int n_fail  = 0;
    int mseq[$];
    logic [3:0] exp_q[$];
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    simon_seq_engine #(.NUM_KEYS(4), .MAX_LEN(3), .SHOW_CYCLES(SC), .GAP_CYCLES(GC),
                       .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .start(start), .key_valid(key_valid), .key_in(key_in),
        .led_out(led_out), .level(level), .busy(busy), .win(win), .lose(lose));

    simon_seq_engine #(.NUM_KEYS(3), .MAX_LEN(4), .SHOW_CYCLES(SC), .GAP_CYCLES(GC),
                       .TIMEOUT_CYCLES(20)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .key_valid(kv3), .key_in(key3),
        .led_out(led3), .level(level3), .busy(busy3), .win(win3), .lose(lose3));

    // Reference Galois LFSR, taps 0xB400, seed 0xACE1, stepping every cycle.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    function automatic int model_idx(input logic [15:0] l, input int nk);
        int kb = (nk <= 2) ? 1 : $clog2(nk);
        int v  = int'(l) & ((1 << kb) - 1);
        if (v >= nk) v -= nk;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after the DUT has entered EXTEND.
    task automatic do_extend();
        mseq.push_back(model_idx(m_lfsr, NK));
        foreach (mseq[i]) exp_q.push_back(4'(1 << mseq[i]));
        tick();
        n_tests++;
        if (level !== 8'(mseq.size()) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL extend_level: got %0d busy %b want %0d busy 1", level, busy, mseq.size());
        end
    endtask

    task automatic playback();
        logic [3:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int c = 0; c < SC; c++) begin
                n_tests++;
                if (led_out !== e || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL show_led: got %b want %b at show cycle %0d", led_out, e, c);
                end
                tick();
            end
            for (int c = 0; c < GC; c++) begin
                n_tests++;
                if (led_out !== 4'b0) begin
                    n_fail++;
                    $display("FAIL gap_led: got %b want 0000 at gap cycle %0d", led_out, c);
                end
                tick();
            end
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_in    = k;
        #1;
        n_tests++;
        if (led_out !== k) begin
            n_fail++;
            $display("FAIL key_echo: got %b want %b", led_out, k);
        end
        tick();
        key_valid = 1'b0;
        key_in    = 4'b0;
    endtask

    task automatic press_all();
        foreach (mseq[i]) press(4'(1 << mseq[i]));
    endtask

    task automatic pregap();
        for (int c = 0; c < GC; c++) begin
            n_tests++;
            if (led_out !== 4'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL pregap_dark: got led %b busy %b want 0000 busy 1", led_out, busy);
            end
            tick();
        end
        do_extend();
    endtask

    task automatic start_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (level !== 8'd0 || busy !== 1'b1 || led_out !== 4'b0 || win !== 1'b0 || lose !== 1'b0) begin
            n_fail++;
            $display("FAIL start_extend: got level %0d busy %b led %b win %b lose %b want 0 1 0000 0 0",
                     level, busy, led_out, win, lose);
        end
        mseq.delete();
        exp_q.delete();
        do_extend();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if (led_out !== 4'b0 || level !== 8'd0 || busy !== 1'b0 || win !== 1'b0 || lose !== 1'b0 ||
            led3 !== 3'b0 || busy3 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got led %b level %0d busy %b win %b lose %b want all 0",
                     led_out, level, busy, win, lose);
        end
        rst = 1'b0;
        repeat (10) tick();
        n_tests++;
        if (busy !== 1'b0 || level !== 8'd0 || led_out !== 4'b0 || win !== 1'b0 || lose !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: got busy %b level %0d led %b want 0 0 0000", busy, level, led_out);
        end
    endtask

    task automatic test_round1();
        start_game();
        playback();
        n_tests++;
        if (busy !== 1'b1 || lose !== 1'b0 || led_out !== 4'b0) begin
            n_fail++;
            $display("FAIL wait_in_idle: got busy %b lose %b led %b want 1 0 0000", busy, lose, led_out);
        end
        press_all();
        pregap();
    endtask

    task automatic test_wrong_key();
        logic [3:0] wrong;
        playback();
        press_all();
        pregap();
        playback();
        press(4'(1 << mseq[0]));
        wrong = 4'(1 << ((mseq[1] + 1) % NK));
        press(wrong);
        n_tests++;
        if (lose !== 1'b1 || level !== 8'd3 || busy !== 1'b0 || win !== 1'b0 || led_out !== 4'b0) begin
            n_fail++;
            $display("FAIL wrong_key_lose: got lose %b level %0d busy %b win %b want 1 3 0 0",
                     lose, level, busy, win);
        end
        start_game();
    endtask

    task automatic test_win();
        playback();
        // start with the final key of the round: key is checked, start ignored
        start = 1'b1;
        press(4'(1 << mseq[0]));
        start = 1'b0;
        pregap();
        start = 1'b1;
        playback();
        start = 1'b0;
        press_all();
        pregap();
        playback();
        press_all();
        n_tests++;
        if (win !== 1'b1 || level !== 8'd3 || busy !== 1'b0 || lose !== 1'b0) begin
            n_fail++;
            $display("FAIL win_state: got win %b level %0d busy %b lose %b want 1 3 0 0",
                     win, level, busy, lose);
        end
        start_game();
    endtask

    task automatic test_invalid();
        key_valid = 1'b1;
        key_in    = 4'b1111;
        playback();
        key_valid = 1'b0;
        key_in    = 4'b0;
        n_tests++;
        if (lose !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL key_during_show: got lose %b busy %b want 0 1", lose, busy);
        end
        press(4'b0110);
        n_tests++;
        if (lose !== 1'b1 || level !== 8'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL multihot_lose: got lose %b level %0d busy %b want 1 1 0", lose, level, busy);
        end
    endtask

    task automatic test_timeout();
        start_game();
        playback();
`ifdef SIMON_TIMEOUT_EN
        repeat (19) tick();
        n_tests++;
        if (lose !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: got lose %b want 0", lose);
        end
        tick();
        n_tests++;
        if (lose !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_lose: got lose %b busy %b want 1 0", lose, busy);
        end
        start_game();
        playback();
        repeat (19) tick();
        press(4'(1 << mseq[0]));
        n_tests++;
        if (lose !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_key_race: got lose %b busy %b want 0 1", lose, busy);
        end
`else
        repeat (40) tick();
        n_tests++;
        if (lose !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_forever: got lose %b busy %b want 0 1", lose, busy);
        end
`endif
    endtask

    task automatic test_nk3();
        int e;
        for (int g = 0; g < 1000; g++) begin
            start3 = 1'b1;
            tick();
            start3 = 1'b0;
            e = model_idx(m_lfsr, 3);
            tick();
            n_tests++;
            if (led3 !== 3'(1 << e) || level3 !== 8'd1) begin
                n_fail++;
                $display("FAIL nk3_key: game %0d got led %b level %0d want %b 1", g, led3, level3, 3'(1 << e));
            end
            repeat (SC + GC) tick();
            kv3  = 1'b1;
            key3 = 3'b000;
            tick();
            kv3  = 1'b0;
            if (g == 0) begin
                n_tests++;
                if (lose3 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL nk3_zero_key: got lose %b want 1", lose3);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_round1();
        test_wrong_key();
        test_win();
        test_invalid();
        test_nk3();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
